// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants for the data-memory arbiter
package dmem_pkg;
    localparam int ADDR_W_DEF = 8;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic [1:0] {
        RP_NONE = 2'd0,
        RP_CPU  = 2'd1,
        RP_HOST = 2'd2
    } rp_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter, one-hot grant
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_mask,
    input  logic       i_lw,
    output logic [1:0] o_gnt
);
    logic [1:0] w_elig;

    // i_mask removes the CPU (bit 0) from contention
    assign w_elig = {i_req[1], i_req[0] & ~i_mask};

    always_comb begin
        o_gnt = 2'b00;
        if (w_elig == 2'b11) begin
            o_gnt = (i_lw == PORT_HOST) ? 2'b01 : 2'b10;
        end else begin
            o_gnt = w_elig;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the D_Memory port between CPU and host
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit HOLD_EN = 1'b1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [31:0]       host_rdata,
    output logic              host_err,
    input  logic              host_hold,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    logic              r_lw;
    rp_t               r_rp;
    logic              r_err;
    logic              r_we;

    logic [1:0]        w_req;
    logic              w_mask;
    logic [1:0]        w_gnt;
    logic              w_any;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic              w_misal;
    logic              w_acc;
    logic [31:0]       w_rd;

    // Requests are ignored while reset is held so no grant escapes
    assign w_req  = {host_req, cpu_req} & {2{~reset}};
    assign w_mask = HOLD_EN && host_hold;

    rr_arb2 u_arb (
        .i_req  (w_req),
        .i_mask (w_mask),
        .i_lw   (r_lw),
        .o_gnt  (w_gnt)
    );

    assign cpu_gnt  = w_gnt[0];
    assign host_gnt = w_gnt[1];
    assign w_any    = |w_gnt;

    assign w_we    = w_gnt[1] ? host_we    : cpu_we;
    assign w_addr  = w_gnt[1] ? host_addr  : cpu_addr;
    assign w_wdata = w_gnt[1] ? host_wdata : cpu_wdata;
    assign w_misal = (w_addr[1:0] != 2'b00);
    assign w_acc   = w_any & ~w_misal;

    assign mem_en    = w_acc;
    assign mem_we    = w_acc & w_we;
    assign mem_addr  = w_acc ? w_addr  : '0;
    assign mem_wdata = w_acc ? w_wdata : '0;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_lw  <= PORT_HOST;
            r_rp  <= RP_NONE;
            r_err <= 1'b0;
            r_we  <= 1'b0;
        end else begin
            if (w_gnt[1]) begin
                r_rp <= RP_HOST;
            end else if (w_gnt[0]) begin
                r_rp <= RP_CPU;
            end else begin
                r_rp <= RP_NONE;
            end
            r_err <= w_any & w_misal;
            r_we  <= w_any & w_we;
            if (w_any) begin
                r_lw <= w_gnt[1];
            end
        end
    end

    // Memory data is only forwarded for an aligned read response
    assign w_rd = (r_rp != RP_NONE && !r_err && !r_we) ? mem_rdata : 32'd0;

    assign cpu_rvalid  = (r_rp == RP_CPU);
    assign host_rvalid = (r_rp == RP_HOST);
    assign cpu_rdata   = cpu_rvalid  ? w_rd : 32'd0;
    assign host_rdata  = host_rvalid ? w_rd : 32'd0;
    assign cpu_err     = cpu_rvalid  & r_err;
    assign host_err    = host_rvalid & r_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    logic        CLOCK_50;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        host_req, host_we, host_gnt, host_rvalid, host_err;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        host_hold;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [7:0]  r_bytes [256];

    int n_vec = 0;
    int n_bad = 0;

    dmem_arbiter #(.ADDR_W(8), .HOLD_EN(1'b1)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .cpu_err     (cpu_err),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .host_err    (host_err),
        .host_hold   (host_hold),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Byte-wide D_Memory, big-endian word view, one-cycle read latency
    always @(posedge CLOCK_50) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) r_bytes[k] <= 8'h00;
            mem_rdata <= 32'd0;
        end else if (mem_en) begin
            if (mem_we) begin
                r_bytes[mem_addr]         <= mem_wdata[31:24];
                r_bytes[mem_addr + 8'd1]  <= mem_wdata[23:16];
                r_bytes[mem_addr + 8'd2]  <= mem_wdata[15:8];
                r_bytes[mem_addr + 8'd3]  <= mem_wdata[7:0];
            end else begin
                mem_rdata <= {r_bytes[mem_addr], r_bytes[mem_addr + 8'd1],
                              r_bytes[mem_addr + 8'd2], r_bytes[mem_addr + 8'd3]};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 8'h00; cpu_wdata = 32'd0;
        host_req = 0; host_we = 0; host_addr = 8'h00; host_wdata = 32'd0;
    endtask

    initial begin
        idle();
        host_hold = 0;
        reset = 1;
        cpu_req = 1; host_req = 1;
        step(); step();
        #1;
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_host_gnt", host_gnt, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_host_rvalid", host_rvalid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_cpu_err", cpu_err, 0);
        check("rst_host_err", host_err, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        idle();
        reset = 0;
        step();

        // Host write 5 to 0x00, then read it back
        host_req = 1; host_we = 1; host_addr = 8'h00; host_wdata = 32'h0000_0005;
        #1;
        check("wr_host_gnt", host_gnt, 1);
        check("wr_cpu_gnt", cpu_gnt, 0);
        check("wr_mem_en", mem_en, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 8'h00);
        check("wr_mem_wdata", mem_wdata, 32'h0000_0005);
        step();
        host_we = 0; host_wdata = 32'd0;
        #1;
        check("wr_host_rvalid", host_rvalid, 1);
        check("wr_host_rdata", host_rdata, 0);
        check("wr_host_err", host_err, 0);
        check("wr_bytes", {r_bytes[0], r_bytes[1], r_bytes[2], r_bytes[3]}, 32'h0000_0005);
        check("rd_host_gnt", host_gnt, 1);
        check("rd_mem_we", mem_we, 0);
        step();
        idle();
        #1;
        check("rd_host_rvalid", host_rvalid, 1);
        check("rd_host_rdata", host_rdata, 32'h0000_0005);

        // Round-robin with both requesting after reset: cpu, host, cpu, host
        reset = 1; step(); reset = 0;
        host_hold = 0;
        for (int k = 0; k < 256; k++) begin end
        step();
        host_req = 1; host_addr = 8'h00; host_wdata = 32'h0000_0005; host_we = 1;
        #1;
        step();
        idle();
        cpu_req = 1; cpu_addr = 8'h00;
        host_req = 1; host_addr = 8'h04;
        // The seeding write made host the last winner, so CPU wins first
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_cpu_gnt", cpu_gnt, (i % 2 == 0));
            check("rr_host_gnt", host_gnt, (i % 2 == 1));
            if (i > 0) begin
                check("rr_cpu_rvalid", cpu_rvalid, (i % 2 == 1));
                check("rr_host_rvalid", host_rvalid, (i % 2 == 0));
                check("rr_cpu_rdata", cpu_rdata, (i % 2 == 1) ? 32'h5 : 32'h0);
            end
            step();
        end
        idle();
        #1;
        check("rr_last_host_rvalid", host_rvalid, 1);
        check("rr_last_cpu_rvalid", cpu_rvalid, 0);
        step();

        // Misaligned CPU load
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h26;
        #1;
        check("mis_cpu_gnt", cpu_gnt, 1);
        check("mis_mem_en", mem_en, 0);
        step();
        idle();
        #1;
        check("mis_cpu_rvalid", cpu_rvalid, 1);
        check("mis_cpu_err", cpu_err, 1);
        check("mis_cpu_rdata", cpu_rdata, 0);
        step();

        // host_hold blocks the CPU, including the cycle it rises
        host_hold = 1; cpu_req = 1; cpu_addr = 8'h00;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("hold_cpu_gnt", cpu_gnt, 0);
            step();
        end
        host_hold = 0;
        #1;
        check("unhold_cpu_gnt", cpu_gnt, 1);
        step();
        idle();
        #1;
        check("unhold_cpu_rvalid", cpu_rvalid, 1);
        check("unhold_cpu_rdata", cpu_rdata, 32'h5);
        step();

        // Reset in the cycle after a CPU read grant discards the response
        cpu_req = 1; cpu_addr = 8'h00;
        #1;
        check("rstmid_cpu_gnt", cpu_gnt, 1);
        step();
        reset = 1;
        idle();
        #1;
        check("rstmid_cpu_rvalid", cpu_rvalid, 0);
        check("rstmid_cpu_rdata", cpu_rdata, 0);
        check("rstmid_mem_en", mem_en, 0);
        step();
        reset = 0;
        step();
        #1;
        check("rstmid_after_rvalid", cpu_rvalid, 0);
        cpu_req = 1; cpu_addr = 8'h00; host_req = 1; host_addr = 8'h04;
        #1;
        check("rstmid_lw_cpu_gnt", cpu_gnt, 1);
        check("rstmid_lw_host_gnt", host_gnt, 0);
        step();
        idle();
        step();

        // Top word store/load and a misaligned access next to it
        host_req = 1; host_we = 1; host_addr = 8'hFC; host_wdata = 32'hDEAD_BEEF;
        #1;
        check("top_host_gnt", host_gnt, 1);
        check("top_mem_addr", mem_addr, 8'hFC);
        step();
        host_we = 0; host_wdata = 32'd0;
        step();
        idle();
        #1;
        check("top_host_rdata", host_rdata, 32'hDEAD_BEEF);
        check("top_byte_fc", r_bytes[8'hFC], 8'hDE);
        check("top_byte_ff", r_bytes[8'hFF], 8'hEF);
        cpu_req = 1; cpu_addr = 8'hFD;
        #1;
        check("fd_cpu_gnt", cpu_gnt, 1);
        check("fd_mem_en", mem_en, 0);
        step();
        idle();
        #1;
        check("fd_cpu_rvalid", cpu_rvalid, 1);
        check("fd_cpu_err", cpu_err, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data-memory port between the CPU load/store unit and a host port. The host port loads matrix operands before a run and reads results back afterwards. It sits between the RISC-V core, the host/debug logic and the byte-wide D_Memory array. It arbitrates round-robin, checks word alignment, and returns big-endian 32-bit words with fixed one-cycle read latency.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of D_Memory (256 bytes).
- HOLD_EN, 1, enables the host_hold input; when 0, host_hold is ignored.

Ports:
- CLOCK_50  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU requests an access this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address of the word.
- cpu_wdata  in  32  store data.
- cpu_gnt  out  1  access accepted this cycle (combinational).
- cpu_rvalid  out  1  read data/ack valid (registered).
- cpu_rdata  out  32  load data.
- cpu_err  out  1  misaligned access flag, same cycle as cpu_rvalid.
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata, host_err  same as the cpu_* ports, for the host.
- host_hold  in  1  when 1, the CPU is never granted (host owns memory).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_wdata  out  32  big-endian word: byte addr+0 = bits 31:24.
- mem_rdata  in  32  read word, valid one cycle after mem_en with mem_we=0.

## Operation
- Each cycle, at most one requester is granted. gnt is combinational from req, host_hold and the last-winner pointer `lw`.
- With a single eligible requester, that requester wins. With both eligible, the port that did not win last wins; `lw` updates on every grant.
- host_hold=1 (and HOLD_EN=1) makes the CPU ineligible. A CPU req stays pending with gnt=0, and no timeout applies.
- Granted and aligned (addr[1:0]==0): mem_en=1, mem_we=we, mem_addr=addr, mem_wdata=wdata.
- Granted and misaligned: mem_en=0. Next cycle rvalid=1, err=1, rdata=0.
- Every granted access, read or write, produces exactly one rvalid pulse to the same port in the next cycle. On a write, rdata=0.
- A requester must hold req/we/addr/wdata stable until it sees gnt. Dropping req before gnt is permitted and cancels the request.
- Internal state: `lw` (1 bit), a pending-response port register `rp` (2 bits: none/cpu/host) and a misaligned flag.

## Timing
- Reset values: all gnt=0, rvalid=0, rdata=0, err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, lw=host (so the CPU wins the first tie), rp=none.
- Grant and memory command are issued in cycle t. rvalid/rdata/err appear in cycle t+1.
- Throughput is one access per cycle. Back-to-back grants to alternating ports are allowed. A response and a new grant may coincide.
- Reset asserted mid-access: the pending response is discarded and no rvalid is produced after reset deasserts.
- host_hold rising in the same cycle as a CPU-only request: the CPU is not granted that cycle.
- Addresses wrap modulo 2^ADDR_W. The top word (addr = 2^ADDR_W-4) is legal.

## Structure
- Package dmem_pkg holds: PORT_CPU=0 and PORT_HOST=1, the rp encoding (RP_NONE, RP_CPU, RP_HOST), and the default ADDR_W.
- One sub-module, rr_arb2. It is a two-input round-robin arbiter: inputs req[1:0] and mask, state lw, output one-hot gnt[1:0].
- Output muxing and the response register stay in dmem_arbiter.

## Test plan
- Host writes 0x00000005 to addr 0x00, then reads it -> host_gnt in the same cycle; the next cycle host_rvalid=1 and host_rdata=0x00000005. Memory bytes: 0x00,0x00,0x00,0x05.
- Both request for 4 consecutive cycles after reset -> grants go cpu, host, cpu, host. Each rvalid pulse goes to the matching port one cycle later.
- CPU load at addr 0x26 -> cpu_gnt=1, mem_en=0. Next cycle cpu_rvalid=1, cpu_err=1, cpu_rdata=0.
- host_hold=1 while the CPU requests for 10 cycles -> cpu_gnt stays 0 throughout. Release host_hold -> cpu_gnt=1 in that same cycle.
- Reset asserted in the cycle after a CPU read grant -> cpu_rvalid stays 0. All outputs are at reset values, and lw=host.
- Store to addr 0xFC (top word) and read it back -> data matches. An access at 0xFD flags err.
